// File: rtl/ofm_stream_pkg.sv
// rtl/ofm_stream_pkg.sv - shared encodings and widths for the OFM BRAM streamer
package ofm_stream_pkg;

  localparam int OFM_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ofm_state_e;

endpackage

// File: rtl/ofm_skid_fifo.sv
// rtl/ofm_skid_fifo.sv - 2-entry output buffer with simultaneous push and pop
module ofm_skid_fifo
  import ofm_stream_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign occupancy = count;
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes everything so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofm_bram_streamer.sv
// rtl/ofm_bram_streamer.sv - streams OFM result BRAM words into the wdma0 valid/ready port
module ofm_bram_streamer
  import ofm_stream_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              ofm_bram_valid,
  input  logic              ofm_bram_ready,
  output logic [DATA_W-1:0] ofm_bram_data,
  output logic              busy,
  output logic              done
);

  ofm_state_e        state;
  ofm_state_e        state_nx;
  logic              start_d;
  logic              start_edge;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  issue_left;
  logic [CNT_W-1:0]  accept_left;
  logic              inflight;
  logic [1:0]        occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_now;
  logic [2:0]        slots_used;

  assign start_edge     = start & ~start_d;
  assign ofm_bram_valid = ~fifo_empty;
  assign pop_now        = ofm_bram_valid & ofm_bram_ready;

  // A word leaving this cycle frees its slot in time for the read issued now,
  // which is what keeps a continuously-ready consumer at one word per clock.
  assign slots_used = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop_now};
  assign bram_en    = (state == ST_RUN) & (issue_left != '0) & (slots_used < 3'd2)
                    & (~fifo_full | pop_now);
  assign bram_addr  = rd_addr;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Delayed copy of start for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_d <= 1'b0;
    end else begin
      start_d <= start;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state: launch on a start edge, finish on the last handshake, release on start low.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nx = (word_count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (pop_now && (accept_left == CNT_W'(1))) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read address, issue/accept counters and the one-cycle in-flight marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr     <= '0;
      issue_left  <= '0;
      accept_left <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= bram_en;
      if ((state == ST_IDLE) && start_edge) begin
        rd_addr     <= base_addr;
        issue_left  <= word_count;
        accept_left <= word_count;
      end else begin
        if (bram_en) begin
          rd_addr    <= rd_addr + ADDR_W'(1);
          issue_left <= issue_left - CNT_W'(1);
        end
        if (pop_now) begin
          accept_left <= accept_left - CNT_W'(1);
        end
      end
    end
  end

  ofm_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bram_dout),
    .pop       (pop_now),
    .head_data (ofm_bram_data),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ofm_bram_streamer.sv
// tb/tb_ofm_bram_streamer.sv - scoreboard bench for ofm_bram_streamer
module tb_ofm_bram_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [28:0] word_count;
  logic        bram_en;
  logic [11:0] bram_addr;
  logic [63:0] bram_dout;
  logic        ofm_bram_valid;
  logic        ofm_bram_ready;
  logic [63:0] ofm_bram_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int tot_en   = 0;
  int tot_hs   = 0;
  int ready_mode = 0;

  logic [11:0] addr_q [$];
  logic [63:0] data_q [$];

  always #5 clk = ~clk;

  ofm_bram_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .bram_en        (bram_en),
    .bram_addr      (bram_addr),
    .bram_dout      (bram_dout),
    .ofm_bram_valid (ofm_bram_valid),
    .ofm_bram_ready (ofm_bram_ready),
    .ofm_bram_data  (ofm_bram_data),
    .busy           (busy),
    .done           (done)
  );

  function automatic logic [63:0] bram_word(input logic [11:0] a);
    return {20'hC0DE0, a, 20'h12340, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM model with one-cycle read latency
  initial begin
    bram_dout = '0;
    forever begin
      @(posedge clk);
      if (bram_en) bram_dout <= bram_word(bram_addr);
    end
  end

  // Consumer ready generator
  initial begin
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    ofm_bram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ofm_bram_ready = 1'b1;
        1: begin ofm_bram_ready = pat[idx % 4]; idx++; end
        2: ofm_bram_ready = 1'($urandom_range(0, 1));
        default: ofm_bram_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected reads and words, checks order, stall stability and outstanding limit
  initial begin
    int issued;
    int accepted;
    logic prev_stall;
    logic [63:0] prev_data;
    logic [63:0] e;
    issued = 0; accepted = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        issued = 0; accepted = 0; prev_stall = 0;
      end else begin
        if (bram_en) begin
          tot_en++; issued++;
          if (addr_q.size() == 0) check("unexpected_read", {52'd0, bram_addr}, 64'hFFFF);
          else begin e = {52'd0, addr_q.pop_front()}; check("rd_addr", {52'd0, bram_addr}, e); end
        end
        if (prev_stall) begin
          check("valid_held", ofm_bram_valid, 1'b1);
          check("data_stable", ofm_bram_data, prev_data);
        end
        if (ofm_bram_valid && ofm_bram_ready) begin
          tot_hs++; accepted++;
          if (data_q.size() == 0) check("unexpected_word", ofm_bram_data, 64'hDEAD);
          else begin e = data_q.pop_front(); check("data", ofm_bram_data, e); end
        end
        if (issued - accepted > 2) check("outstanding_le_2", 64'(issued - accepted), 64'd2);
        prev_stall = ofm_bram_valid & ~ofm_bram_ready;
        prev_data  = ofm_bram_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [11:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      addr_q.push_back(base + 12'(i));
      data_q.push_back(bram_word(base + 12'(i)));
    end
    base_addr  = base;
    word_count = 29'(cnt);
    start      = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic finish_and_idle();
    start = 1'b0;
    tick();
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("queues_empty", 64'(addr_q.size() + data_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int en0;
    int hs0;
    int k;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) tick();
    check("rst_bram_en", bram_en, 1'b0);
    check("rst_bram_addr", {52'd0, bram_addr}, 64'd0);
    check("rst_valid", ofm_bram_valid, 1'b0);
    check("rst_data", ofm_bram_data, 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: eight words at full rate
    ready_mode = 0;
    launch(12'h010, 8);
    tick();
    check("t1_busy", busy, 1'b1);
    check("t1_valid_c1", ofm_bram_valid, 1'b0);
    tick();
    check("t1_valid_c2", ofm_bram_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t1_valid_stream", ofm_bram_valid, 1'b1);
    end
    tick();
    check("t1_done", done, 1'b1);
    check("t1_valid_after", ofm_bram_valid, 1'b0);
    finish_and_idle();

    // 2: sixteen words with ready pattern then random ready
    hs0 = tot_hs;
    ready_mode = 1;
    launch(12'h300, 16);
    repeat (12) tick();
    ready_mode = 2;
    wait_done(400);
    check("t2_handshakes", 64'(tot_hs - hs0), 64'd16);
    ready_mode = 0;
    finish_and_idle();

    // 3: address wrap
    hs0 = tot_hs;
    launch(12'hFFE, 4);
    wait_done(50);
    check("t3_handshakes", 64'(tot_hs - hs0), 64'd4);
    finish_and_idle();

    // 4: zero-length transfer
    en0 = tot_en;
    launch(12'h050, 0);
    tick();
    check("t4_done", done, 1'b1);
    check("t4_valid", ofm_bram_valid, 1'b0);
    tick();
    check("t4_no_reads", 64'(tot_en - en0), 64'd0);
    finish_and_idle();

    // 5: reset after three of ten words, then a fresh two-word transfer
    hs0 = tot_hs;
    launch(12'h080, 10);
    k = 0;
    while ((tot_hs - hs0) < 3 && k < 50) begin
      tick();
      k++;
    end
    check("t5_three_accepted", 64'(tot_hs - hs0), 64'd3);
    rst_n = 1'b0; start = 1'b0;
    ready_mode = 3; ofm_bram_ready = 1'b0;
    tick();
    check("t5_rst_valid", ofm_bram_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    addr_q.delete();
    data_q.delete();
    tick();
    rst_n = 1'b1;
    ready_mode = 0;
    tick();
    hs0 = tot_hs;
    launch(12'h100, 2);
    wait_done(50);
    check("t5_handshakes", 64'(tot_hs - hs0), 64'd2);
    finish_and_idle();

    // 6: start re-pulse during RUN and start held high in DONE
    en0 = tot_en;
    hs0 = tot_hs;
    launch(12'h200, 6);
    tick();
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("t6_still_run", busy & ~done, 1'b1);
    wait_done(50);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_done_held", done, 1'b1);
    end
    check("t6_reads", 64'(tot_en - en0), 64'd6);
    check("t6_handshakes", 64'(tot_hs - hs0), 64'd6);
    finish_and_idle();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
